// File: rtl/gray_run_ctrl.sv
// gray_run_ctrl: sequences a 5-bit Gray counter (enable/reset_L) for N steps
// with pause/abort, and optionally checks each observed step is single-bit.
// Ports: clk, reset_L (async, active-low); start/steps/hold/abort control;
//   gray_in counter output; cnt_enable/cnt_reset_L drive the counter;
//   busy, done (pulse), err (sticky), steps_done (advances issued).
// Optional macro GRAY_CHECK_EN compiles in the Gray monitor; else err=0.
module gray_run_ctrl #(
  parameter int GRAY_W = 5,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              start,
  input  logic [CNT_W-1:0]  steps,
  input  logic              hold,
  input  logic              abort,
  input  logic [GRAY_W-1:0] gray_in,
  output logic              cnt_enable,
  output logic              cnt_reset_L,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  steps_done
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    PAUSE,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT = '1;

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] remaining_nx;
  logic [CNT_W-1:0] steps_done_nx;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = CLEAR;
          accept   = 1'b1;
        end
      end
      CLEAR: begin
        state_nx = (remaining != '0) ? RUN : DRAIN;
      end
      RUN: begin
        // the last advance always completes, hold is ignored there
        if (remaining == ONE) begin
          state_nx = DRAIN;
        end else if (hold) begin
          state_nx = PAUSE;
        end
      end
      PAUSE: begin
        if (!hold) begin
          state_nx = RUN;
        end
      end
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort && (state inside {CLEAR, RUN, PAUSE, DRAIN})) begin
      state_nx = IDLE;
    end
  end

  // a RUN cycle always issues an advance, even when it is aborted
  always_comb begin
    remaining_nx  = remaining;
    steps_done_nx = steps_done;
    if (accept) begin
      remaining_nx  = steps;
      steps_done_nx = '0;
    end else if (state == RUN) begin
      remaining_nx = remaining - ONE;
      if (steps_done != SAT) begin
        steps_done_nx = steps_done + ONE;
      end
    end
  end

  // outputs are decoded from the next state so they line up with it
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      remaining   <= '0;
      steps_done  <= '0;
      cnt_enable  <= 1'b0;
      cnt_reset_L <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      remaining   <= remaining_nx;
      steps_done  <= steps_done_nx;
      cnt_enable  <= (state_nx == RUN);
      cnt_reset_L <= (state_nx != CLEAR);
      busy        <= (state_nx != IDLE);
      done        <= (state_nx == DONE);
    end
  end

`ifdef GRAY_CHECK_EN
  logic [GRAY_W-1:0] gray_prev;
  logic [GRAY_W-1:0] diff;
  logic              en_d;
  logic              first_chk;
  logic              chk;
  logic              bad;

  // skip CLEAR: the counter may be resetting underneath us
  assign chk  = busy && (state != CLEAR);
  assign diff = gray_in ^ gray_prev;

  always_comb begin
    bad = 1'b0;
    if (first_chk) begin
      bad = (gray_in != '0);
    end else if (en_d) begin
      bad = ($countones(diff) != 1);
    end else begin
      bad = (diff != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      gray_prev <= '0;
      en_d      <= 1'b0;
      first_chk <= 1'b0;
      err       <= 1'b0;
    end else begin
      gray_prev <= gray_in;
      en_d      <= cnt_enable;
      first_chk <= (state == CLEAR);
      if (accept) begin
        err <= 1'b0;
      end else if (chk && bad) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_gray;

  assign unused_gray = ^gray_in;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_gray_run_ctrl.sv
// tb_gray_run_ctrl: directed and random runs of gray_run_ctrl driving a
// behavioural Gray counter; checks timing aggregates, counts and err trace.
module tb_gray_run_ctrl;

  localparam int GW = 5;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          start;
  logic          hold;
  logic          abort;
  logic [CW-1:0] steps;
  logic [GW-1:0] gray_in;
  logic [GW-1:0] mask;
  logic [GW-1:0] cnt = '0;
  logic          cnt_enable;
  logic          cnt_reset_L;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] steps_done;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gray_run_ctrl #(
    .GRAY_W(GW),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .start      (start),
    .steps      (steps),
    .hold       (hold),
    .abort      (abort),
    .gray_in    (gray_in),
    .cnt_enable (cnt_enable),
    .cnt_reset_L(cnt_reset_L),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .steps_done (steps_done)
  );

  function automatic logic [GW-1:0] g5(input int v);
    logic [GW-1:0] b;
    b = GW'(v);
    return b ^ (b >> 1);
  endfunction

  always @(posedge clk) begin
    if (!cnt_reset_L) cnt <= '0;
    else if (cnt_enable) cnt <= cnt + 1'b1;
  end

  assign gray_in = g5(int'(cnt)) ^ mask;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int n, input int hold_after, input int hold_len,
                     input int abort_after, input int corrupt_c,
                     input bit poke);
    int c, lim, adv, en_cnt, en_first, en_last, done_cnt, done_c;
    int busy_cnt, busy_last, rl_cnt, rl_first, err_bad, hold_left, ca;
    int xp_pause, xp_done, xp_adv, win_end, sd_last;
    bit hold_up, aborted, viol_any, viol, en_prev, xp_err;
    logic [GW-1:0] gcur, gprev, gfin;
    xp_pause = (hold_after >= 1 && hold_after < n) ? hold_len : 0;
    xp_done  = 3 + n + xp_pause;
    xp_adv   = (abort_after > 0) ? abort_after : n;
    lim      = (abort_after > 0) ? n + 10 : xp_done + 1;
    win_end  = (abort_after > 0) ? (1 << 30) : xp_done;
    adv = 0; en_cnt = 0; en_first = -1; en_last = -1;
    done_cnt = 0; done_c = -1; busy_cnt = 0; busy_last = -1;
    rl_cnt = 0; rl_first = -1; err_bad = 0; hold_left = 0; ca = -1;
    sd_last = 0; hold_up = 0; aborted = 0; viol_any = 0; en_prev = 0;
    gprev = '0; gfin = '0;
    @(negedge clk);
    mask = '0; start = 1; steps = CW'(n); hold = 0; abort = 0;
    @(negedge clk);
    start = 0;
    c = 1;
    while (c <= lim) begin
      abort = 0;
      start = 0;
      if (c == corrupt_c) mask = 5'b00011;
      gcur = g5(int'(cnt)) ^ mask;
      if (cnt_enable) begin
        adv++; en_cnt++;
        if (en_first < 0) en_first = c;
        en_last = c;
      end
      if (done) begin done_cnt++; done_c = c; end
      if (busy) begin busy_cnt++; busy_last = c; end
      if (!cnt_reset_L) begin
        rl_cnt++;
        if (rl_first < 0) rl_first = c;
      end
`ifdef GRAY_CHECK_EN
      xp_err = viol_any;
`else
      xp_err = 0;
`endif
      if (err !== xp_err) err_bad++;
      if (!aborted && c >= 2 && c <= win_end) begin
        if (c == 2) viol = (gcur != '0);
        else viol = ($countones(gcur ^ gprev) != (en_prev ? 1 : 0));
        viol_any = viol_any | viol;
      end
      gprev = gcur;
      en_prev = cnt_enable;
      sd_last = int'(steps_done);
      gfin = g5(int'(cnt));
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) hold = 0;
      end
      if (!hold_up && cnt_enable && adv == hold_after) begin
        hold_up = 1; hold = 1; hold_left = hold_len;
      end
      if (!aborted && cnt_enable && adv == abort_after) begin
        abort = 1; start = 1; aborted = 1; ca = c; lim = c + 3;
      end
      if (poke && c == 2) start = 1;
      @(negedge clk);
      c++;
    end
    start = 0; abort = 0; hold = 0;
    check("rst_low_cnt", rl_cnt, 1);
    check("rst_low_at", rl_first, 1);
    check("enable_cnt", en_cnt, xp_adv);
    if (abort_after > 0) begin
      check("abort_at", ca, 1 + abort_after);
      check("done_cnt", done_cnt, 0);
      check("busy_cnt", busy_cnt, 1 + abort_after);
      check("busy_last", busy_last, 1 + abort_after);
    end else begin
      check("done_cnt", done_cnt, 1);
      check("done_at", done_c, xp_done);
      check("busy_cnt", busy_cnt, xp_done);
      check("busy_last", busy_last, xp_done);
      if (n > 0) begin
        check("en_first", en_first, 2);
        check("en_last", en_last, 1 + n + xp_pause);
      end
    end
    check("steps_done", sd_last, xp_adv);
    check("gray_final", gfin, g5(xp_adv));
    check("err_trace", err_bad, 0);
  endtask

  initial begin
    reset_L = 0; start = 0; hold = 0; abort = 0; steps = '0; mask = '0;
    repeat (3) @(negedge clk);
    check("reset_state",
          {cnt_enable, cnt_reset_L, busy, done, err, steps_done}, 0);
    reset_L = 1;
    @(negedge clk);
    check("idle_cnt_reset_L", cnt_reset_L, 1);
    check("idle_busy", busy, 0);

    run(5, -1, 0, -1, -1, 0);
    run(32, -1, 0, -1, -1, 1);
    run(20, 10, 3, -1, -1, 0);
    run(10, -1, 0, 4, -1, 0);
    run(12, -1, 0, -1, 6, 0);
    run(3, -1, 0, -1, -1, 0);
    run(6, 6, 2, -1, -1, 0);
    run(1, -1, 0, 1, -1, 0);

    @(negedge clk);
    start = 1; steps = CW'(15);
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    check("midrun_enable", cnt_enable, 1);
    #2 reset_L = 0;
    #1 check("async_reset",
             {cnt_enable, cnt_reset_L, busy, done, err, steps_done}, 0);
    @(negedge clk);
    @(negedge clk);
    reset_L = 1;
    run(0, -1, 0, -1, -1, 0);

    for (int i = 0; i < 12; i++) begin
      int n, m;
      n = $urandom_range(1, 40);
      m = $urandom_range(0, 3);
      case (m)
        0: run(n, -1, 0, -1, -1, 1);
        1: run(n, $urandom_range(1, n), $urandom_range(1, 4), -1, -1, 0);
        2: run(n, -1, 0, $urandom_range(1, n), -1, 0);
        default: run(n, -1, 0, -1, $urandom_range(2, n + 3), 0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_run_ctrl.md
Name: gray_run_ctrl

Overview:
Sequencing controller for the 5-bit Gray counter datapath (behavioural or structural instance).
- Drives the counter's enable and reset_L to run a programmed number of count steps, with pause and abort support.
- Monitors the counter output on every cycle and flags any transition that is not a single-bit Gray step.
- Sits between the test/control logic and the counter; replaces hand-driven enable/reset_L sequencing.

Parameters:
GRAY_W, 5, width of observed Gray counter output
CNT_W, 10, width of step-count request and progress counter (max 1023 steps)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_L  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to begin a run; sampled only in IDLE
steps  input  CNT_W  number of counter advances for the run; latched on accepted start
hold  input  1  level; pauses the run while high
abort  input  1  single-cycle request to terminate the run
gray_in  input  GRAY_W  counter output being sequenced/monitored
cnt_enable  output  1  drives counter enable
cnt_reset_L  output  1  drives counter reset_L
busy  output  1  high from accepted start until return to IDLE
done  output  1  one-cycle pulse on normal completion
err  output  1  sticky Gray-sequence violation flag
steps_done  output  CNT_W  advances issued in current/last run

Behaviour:
- All outputs are registered. Reset values while reset_L=0: cnt_enable=0, cnt_reset_L=0, busy=0, done=0, err=0, steps_done=0, FSM=IDLE.
- Reset takes effect asynchronously, mid-run included; no done pulse is produced.
- States: IDLE, CLEAR, RUN, PAUSE, DRAIN, DONE.
- IDLE: cnt_reset_L=1, cnt_enable=0.
  - start=1: latch steps into remaining, steps_done<=0, err<=0, go to CLEAR.
  - start=0: no state change.
- CLEAR (1 cycle): cnt_reset_L=0, busy=1. Next state is RUN if remaining!=0, else DRAIN.
- RUN: cnt_enable=1.
  - Each RUN cycle: remaining-1, steps_done+1.
  - If remaining==1, next state is DRAIN.
  - Otherwise, if hold=1, next state is PAUSE.
- PAUSE: cnt_enable=0. When hold=0, return to RUN.
- DRAIN (1 cycle): cnt_enable=0; allows the final transition to be checked.
- DONE (1 cycle): done=1, busy=0 on exit, then IDLE.
- Latency: start sampled at edge k gives CLEAR during cycle k+1 and cnt_enable high for exactly `steps` RUN cycles starting at k+2 (pauses excluded). done is high in cycle k+3+steps+pause_cycles.
- abort=1 in CLEAR/RUN/PAUSE/DRAIN: go to IDLE next edge.
  - cnt_enable=0 and busy=0 from the next cycle; no done pulse.
  - steps_done holds the advances already issued.
- Priority: abort > hold. start while busy is ignored. hold on the final RUN cycle is ignored (the run completes).
- Gray monitor:
  - gray_prev is registered every cycle.
  - en_d is cnt_enable delayed one cycle.
  - In the first cycle after CLEAR, gray_in must equal 0.
  - Afterwards, while busy: if en_d=1, popcount(gray_in ^ gray_prev) must be 1; if en_d=0, it must be 0.
  - Any violation sets err=1. err stays set until the next accepted start or reset. The run continues regardless.
- Wrap-around: the 10000 -> 00000 transition is a legal single-bit step, so no err is flagged.
- steps_done saturates at 2^CNT_W-1 and never wraps.

Optional Feature:
GRAY_CHECK_EN
- Defined: the Gray monitor (gray_prev, en_d, popcount compare) is compiled in, and err behaves as above.
- Undefined: the monitor logic is removed, err is tied to 0, gray_in is unused, and sequencing is unchanged.

Test Plan:
1. Reset, then start with steps=5 -> cnt_reset_L low 1 cycle, cnt_enable high 5 consecutive cycles; gray_in ends at 00111; done pulses once; steps_done=5; err=0.
2. start with steps=32 -> counter wraps to 00000; err=0; steps_done=32; done pulses.
3. steps=20, hold high 3 cycles after 10 advances -> cnt_enable low exactly 3 cycles; total high cycles=20; final gray_in=11110; err=0.
4. steps=10, abort after 4 advances -> busy=0 next cycle; no done; steps_done=4; a start issued the same cycle as abort is ignored.
5. With GRAY_CHECK_EN, bench corrupts gray_in with a two-bit change mid-run -> err=1 within one cycle, stays 1; done still pulses; next start clears err.
6. Drop reset_L mid-run -> cnt_enable=0, cnt_reset_L=0, busy=0, steps_done=0 asynchronously; start with steps=0 after release -> CLEAR, DRAIN, done pulse; cnt_enable never high.
